// File: rtl/rom_arbiter.sv
// Two-port round-robin arbiter in front of a handshaked ROM, with an abort on
// a stuck ROM. One access is outstanding at a time; every output is registered.
module rom_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        req1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        err,
    output logic        rom_cs,
    output logic [15:0] rom_addr,
    input  logic        rom_ready,
    input  logic [15:0] rom_data
);

    localparam int unsigned DW            = 16;
    localparam int unsigned CW            = 8;
    localparam int unsigned SETTLE_CYCLES = 2;

    typedef enum logic [2:0] {
        SETTLE,
        IDLE,
        ISSUE,
        WAIT_LOW,
        WAIT_HIGH
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic            last_grant, last_grant_d;
    logic            grant_id, grant_id_d;
    logic            pick_c;
    logic            done_ok_c, done_to_c;
    logic            rom_cs_d;
    logic [DW-1:0]   rom_addr_d;
    logic            ack0_d, ack1_d, err_d;
    logic [DW-1:0]   rdata_d;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state;
        cnt_d        = cnt;
        last_grant_d = last_grant;
        grant_id_d   = grant_id;
        pick_c       = 1'b0;
        done_ok_c    = 1'b0;
        done_to_c    = 1'b0;
        rom_cs_d     = 1'b0;
        rom_addr_d   = rom_addr;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata;

        case (state)
            SETTLE: begin
                if (cnt == CW'(SETTLE_CYCLES - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the port that did not win last time goes first
                    pick_c     = (req0 && req1) ? ~last_grant : req1;
                    grant_id_d = pick_c;
                    rom_addr_d = pick_c ? addr1 : addr0;
                    rom_cs_d   = 1'b1;
                    cnt_d      = '0;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_LOW;
            end
            WAIT_LOW, WAIT_HIGH: begin
                if (state == WAIT_HIGH && rom_ready) begin
                    done_ok_c = 1'b1;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    done_to_c = 1'b1;
                end else begin
                    cnt_d = cnt + CW'(1);
                    if (state == WAIT_LOW && !rom_ready) begin
                        state_d = WAIT_HIGH;
                    end
                end
            end
            default: begin
                state_d = SETTLE;
                cnt_d   = '0;
            end
        endcase

        // Completion, normal or aborted: rdata only ever loads here
        if (done_ok_c || done_to_c) begin
            ack0_d       = ~grant_id;
            ack1_d       = grant_id;
            err_d        = done_to_c;
            rdata_d      = done_to_c ? 16'hFFFF : rom_data;
            last_grant_d = grant_id;
            state_d      = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SETTLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            rom_cs     <= 1'b0;
            rom_addr   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            err        <= 1'b0;
            rdata      <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            last_grant <= last_grant_d;
            grant_id   <= grant_id_d;
            rom_cs     <= rom_cs_d;
            rom_addr   <= rom_addr_d;
            ack0       <= ack0_d;
            ack1       <= ack1_d;
            err        <= err_d;
            rdata      <= rdata_d;
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: bench-side ROM, transaction-level reference
// model compared every cycle, plus literal checks on each scenario.
module tb_rom_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1;
    logic [15:0] addr0, addr1;
    logic        ack0, ack1, err, rom_cs;
    logic [15:0] rdata, rom_addr;
    logic        rom_ready;
    logic [15:0] rom_data;

    logic        rom_stuck;
    logic        chk_en;
    int          n_tests, n_fail;
    int          c_tests, c_fail;

    localparam logic [15:0] GARBAGE = 16'hDEAD;

    rom_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err),
        .rom_cs(rom_cs), .rom_addr(rom_addr),
        .rom_ready(rom_ready), .rom_data(rom_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        case (a)
            16'd0:   rom_word = 16'h0028;
            16'd1:   rom_word = 16'h01F4;
            16'd2:   rom_word = 16'h0029;
            16'd3:   rom_word = 16'h0032;
            default: rom_word = 16'h1000 + a * 16'd7;
        endcase
    endfunction

    // ROM: ready drops the cycle after cs, data+ready the next; the floating bus is garbage
    int ph;
    always @(posedge clk) begin
        if (rst || rom_stuck) begin
            ph        <= 0;
            rom_ready <= 1'b1;
            rom_data  <= GARBAGE;
        end else if (ph == 0 && rom_cs) begin
            rom_ready <= 1'b0;
            ph        <= 1;
        end else if (ph == 1) begin
            rom_ready <= 1'b1;
            rom_data  <= rom_word(rom_addr);
            ph        <= 2;
        end else if (ph == 2) begin
            rom_data  <= GARBAGE;
            ph        <= 0;
        end
    end

    // Reference model: one outstanding access, completion after a fixed ROM latency
    int          m_settle, m_age, m_lim;
    bit          m_busy, m_id, m_last;
    logic [15:0] m_addr;
    logic        e_ack0 = 1'b0, e_ack1 = 1'b0, e_err = 1'b0, e_cs = 1'b0;
    logic [15:0] e_addr = 16'h0, e_rdata = 16'h0;

    always @(posedge clk) begin
        e_ack0 = 1'b0;
        e_ack1 = 1'b0;
        e_err  = 1'b0;
        e_cs   = 1'b0;
        if (rst) begin
            m_settle = 2;
            m_busy   = 1'b0;
            m_last   = 1'b1;
            e_addr   = 16'h0;
            e_rdata  = 16'h0;
        end else if (m_settle > 0) begin
            m_settle = m_settle - 1;
        end else if (m_busy) begin
            m_age = m_age + 1;
            if (m_age == m_lim) begin
                m_busy  = 1'b0;
                e_ack0  = !m_id;
                e_ack1  = m_id;
                e_err   = (m_lim != 3);
                e_rdata = (m_lim != 3) ? 16'hFFFF : rom_word(m_addr);
                m_last  = m_id;
            end
        end else if (req0 || req1) begin
            m_id   = (req0 && req1) ? !m_last : req1;
            m_addr = m_id ? addr1 : addr0;
            m_busy = 1'b1;
            m_age  = 0;
            m_lim  = rom_stuck ? 17 : 3;
            e_cs   = 1'b1;
            e_addr = m_addr;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            c_tests++;
            if ({ack0, ack1, err, rom_cs} !== {e_ack0, e_ack1, e_err, e_cs} ||
                rom_addr !== e_addr || rdata !== e_rdata) begin
                c_fail++;
                $display("FAIL cycle t=%0t: got ack0=%b ack1=%b err=%b cs=%b addr=%h rdata=%h, expected ack0=%b ack1=%b err=%b cs=%b addr=%h rdata=%h",
                         $time, ack0, ack1, err, rom_cs, rom_addr, rdata,
                         e_ack0, e_ack1, e_err, e_cs, e_addr, e_rdata);
            end
        end
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One access on a port; latency counts edges from the sampling edge to the ack
    task automatic run_single(input string name, input logic port, input logic [15:0] a,
                              input logic [15:0] exp_d, input logic exp_e,
                              input int exp_lat, input bit drop_early);
        int n;
        bit seen;
        @(negedge clk);
        if (port) begin req1 = 1'b1; addr1 = a; end
        else      begin req0 = 1'b1; addr0 = a; end
        n = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack0 || ack1) seen = 1'b1;
            else if (drop_early && n == 1) begin
                req0 = 1'b0; req1 = 1'b0;
                addr0 = ~a;  addr1 = ~a;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no ack expected ack within 40 cycles", name);
        end else begin
            check16({name, "_port"}, 16'(ack1), 16'(port));
            check16({name, "_rdata"}, rdata, exp_d);
            check16({name, "_err"}, 16'(err), 16'(exp_e));
            check_int({name, "_latency"}, n, exp_lat);
        end
    endtask

    initial begin
        logic [15:0] pair_d[4];
        logic        pair_p[4];
        int k, n;
        pair_d = '{16'h01F4, 16'h0032, 16'h01F4, 16'h0032};
        pair_p = '{1'b0, 1'b1, 1'b0, 1'b1};
        n_tests = 0; n_fail = 0; c_tests = 0; c_fail = 0;
        chk_en = 1'b0;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        addr0 = 16'h0; addr1 = 16'h0; rom_stuck = 1'b0;

        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check16("reset_cs", 16'(rom_cs), 16'h0);
        check16("reset_acks", 16'({ack0, ack1, err}), 16'h0);
        check16("reset_rdata", rdata, 16'h0);
        check16("reset_addr", rom_addr, 16'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        run_single("single0", 1'b0, 16'd0, 16'h0028, 1'b0, 4, 1'b0);
        run_single("only1_a", 1'b1, 16'd6, rom_word(16'd6), 1'b0, 4, 1'b0);
        run_single("only1_b", 1'b1, 16'd3, 16'h0032, 1'b0, 4, 1'b0);
        run_single("only1_c", 1'b1, 16'd9, rom_word(16'd9), 1'b0, 4, 1'b0);

        // Both held: grants alternate, each ack cycle's held req is a fresh request
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; addr0 = 16'd1; addr1 = 16'd3;
        k = 0; n = 0;
        while (k < 4 && n < 60) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (ack0 || ack1) begin
                check16("pair_port", 16'(ack1), 16'(pair_p[k]));
                check16("pair_rdata", rdata, pair_d[k]);
                k++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        check_int("pair_acks", k, 4);
        check_int("pair_cycles", n, 16);

        @(negedge clk);
        rom_stuck = 1'b1;
        run_single("timeout", 1'b0, 16'd5, 16'hFFFF, 1'b1, 18, 1'b0);
        rom_stuck = 1'b0;

        run_single("drop_req", 1'b0, 16'd4, rom_word(16'd4), 1'b0, 4, 1'b1);

        // Reset landing in the WAIT_HIGH cycle drops the access
        @(negedge clk);
        req0 = 1'b1; addr0 = 16'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; req0 = 1'b0;
        @(negedge clk);
        check16("rst_mid_ack", 16'({ack0, ack1}), 16'h0);
        check16("rst_mid_rdata", rdata, 16'h0);
        rst = 1'b0;
        check16("settle1_cs", 16'(rom_cs), 16'h0);
        @(negedge clk);
        check16("settle2_cs", 16'(rom_cs), 16'h0);
        @(negedge clk);
        run_single("after_rst", 1'b0, 16'd2, 16'h0029, 1'b0, 4, 1'b0);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests + c_tests, n_fail + c_fail);
        $finish;
    end

endmodule
